chip8_rand_arbiter: RTL and testbench

Sequences and shares the free-running 16-bit pseudo-random generator among `NUM_REQ` requesters, such as the CPU's CXNN execute stage and auxiliary consumers. It serves requests with a four-phase req/ack handshake. Each grant delivers a masked, byte-folded sample. A decimation counter guarantees that successive grants never reuse the same or an adjacent generator state. The block sits between `Chip8_rand_num_generator` and the CPU/peripheral consumers, all on `cpu_clk`.

---
 rtl/chip8_rand_arbiter.sv | 136 +++++++++++++
 tb/tb_chip8_rand_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_rand_arbiter.sv
// Purpose : shares the free-running 16-bit PRNG among NUM_REQ requesters, handing out one masked, byte-folded sample per grant.
// Latency : ack/rand_byte registered, 2 edges after req is first sampled when decim_cnt==0 and rand_num!=0; grants spaced >= max(DECIM+1,3).
// Backpress: four-phase req/ack; the winner holds the block in HOLD until it drops req, others simply keep req high.
//
// Ports:
//   cpu_clk    - sole clock, rising edge
//   reset      - asynchronous, active-high
//   rand_num   - current generator state (0 means reseeding, never sampled)
//   req        - per-requester request level, index 0 is the CPU
//   mask       - per-requester AND mask, requester i uses bits [8i+7:8i]
//   ack        - one-hot, one-cycle grant pulse
//   rand_byte  - sample, valid in the ack cycle and held until the next grant
//   busy       - high whenever the arbiter is not IDLE
//   draw_count - completed grants, wraps at 16 bits
module chip8_rand_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DECIM   = 3
) (
    input  logic                   cpu_clk,
    input  logic                   reset,
    input  logic [15:0]            rand_num,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   mask,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             rand_byte,
    output logic                   busy,
    output logic [15:0]            draw_count
);

    localparam int                 IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0]      LAST_INIT = IW'(NUM_REQ - 1);
    localparam logic [3:0]         DECIM_LD  = 4'(DECIM);
    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] winner;
    logic [IW-1:0] last_winner;
    logic [3:0]    decim_cnt;

    logic [IW-1:0] rr_pick;
    logic          rr_found;
    logic [7:0]    mask_arr [NUM_REQ];
    logic [7:0]    folded;
    logic          sample_ok;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
        assign mask_arr[i] = mask[8*i +: 8];
    end

    // Folding both halves keeps every generator bit contributing to the byte.
    assign folded = rand_num[15:8] ^ rand_num[7:0];

    // An all-zero state marks a generator reseed; the decimation count keeps
    // consecutive samples at least DECIM+1 generator steps apart.
    assign sample_ok = (decim_cnt == 4'd0) && (rand_num != 16'd0);

    // Round-robin: scan from last_winner+1 upward (wrapping), first high bit wins.
    always_comb begin
        int idx;
        idx      = 0;
        rr_pick  = last_winner;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_winner) + k) % NUM_REQ;
            if (!rr_found && req[idx]) begin
                rr_pick  = IW'(idx);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            winner      <= '0;
            last_winner <= LAST_INIT;
            decim_cnt   <= 4'd0;
            ack         <= '0;
            rand_byte   <= 8'h00;
            busy        <= 1'b0;
            draw_count  <= 16'h0000;
        end else begin
            ack <= '0;

            // Free-running saturating countdown; a grant below reloads it.
            if (decim_cnt != 4'd0) begin
                decim_cnt <= decim_cnt - 4'd1;
            end

            case (state)
                IDLE: begin
                    if (rr_found) begin
                        winner <= rr_pick;
                        state  <= DRAW;
                        busy   <= 1'b1;
                    end
                end

                DRAW: begin
                    if (!req[winner]) begin
                        // Withdrawn before service: no ack, fairness pointer untouched.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sample_ok) begin
                        rand_byte   <= folded & mask_arr[winner];
                        ack         <= ONE << winner;
                        decim_cnt   <= DECIM_LD;
                        last_winner <= winner;
                        draw_count  <= draw_count + 16'd1;
                        state       <= HOLD;
                    end
                end

                HOLD: begin
                    // Completes the four-phase handshake; other requests wait.
                    if (!req[winner]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_rand_arbiter.sv
// Purpose : self-checking bench for chip8_rand_arbiter, directed spec cases plus randomized transactions.
// Latency : predicts the exact grant edge from request time, last grant and generator zeros.
// Backpress: requesters hold req until acked, then drop after 0..2 cycles; idle gaps drop all requests.
module tb_chip8_rand_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DECIM   = 3;
    localparam int MW      = NUM_REQ * 8;
    localparam int MIN_GAP = (DECIM + 1 > 3) ? DECIM + 1 : 3;

    logic               cpu_clk = 1'b0;
    logic               reset;
    logic [15:0]        rand_num;
    logic [NUM_REQ-1:0] req;
    logic [MW-1:0]      mask;
    logic [NUM_REQ-1:0] ack;
    logic [7:0]         rand_byte;
    logic               busy;
    logic [15:0]        draw_count;

    int n_vec   = 0;
    int n_bad   = 0;
    int edge_no = 0;

    // Reference model state (transaction level)
    int          model_last;
    logic [15:0] model_count;
    logic [7:0]  model_byte;
    int          last_grant_edge;
    int          last_ack_obs;

    // Data-generation knobs
    bit          fix_en;
    logic [15:0] fix_rn;
    logic [MW-1:0] fix_mask;
    int          zero_cycles;
    int          zero_pct;

    chip8_rand_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DECIM   (DECIM)
    ) dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .rand_num   (rand_num),
        .req        (req),
        .mask       (mask),
        .ack        (ack),
        .rand_byte  (rand_byte),
        .busy       (busy),
        .draw_count (draw_count)
    );

    always #5 cpu_clk = ~cpu_clk;
    always @(posedge cpu_clk) edge_no <= edge_no + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    function automatic logic [7:0] fold(input logic [15:0] v);
        return v[15:8] ^ v[7:0];
    endfunction

    // Lowest offset k in 1..NUM_REQ from the last winner whose request is high.
    function automatic int rr_model(input logic [NUM_REQ-1:0] s, input int last);
        int pick;
        pick = -1;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (s[(last + k) % NUM_REQ]) pick = (last + k) % NUM_REQ;
        end
        return pick;
    endfunction

    task automatic drive_data(input int c);
        if (c < zero_cycles)                            rand_num = 16'h0000;
        else if (fix_en)                                rand_num = fix_rn;
        else if (int'($urandom_range(0, 99)) < zero_pct) rand_num = 16'h0000;
        else                                            rand_num = 16'($urandom);
        mask = fix_en ? fix_mask : MW'({$urandom, $urandom});
    endtask

    task automatic model_reset();
        model_last      = NUM_REQ - 1;
        model_count     = 16'h0000;
        model_byte      = 8'h00;
        last_grant_edge = -1000;
        last_ack_obs    = -1000;
    endtask

    task automatic idle_ticks(input int n);
        req = '0;
        for (int i = 0; i < n; i++) begin
            drive_data(1000);
            tick();
            chk_eq("idle_ack", 32'(ack), 32'd0);
            chk_eq("idle_busy", 32'(busy), 32'd0);
            chk_eq("idle_byte", 32'(rand_byte), 32'(model_byte));
            chk_eq("idle_count", 32'(draw_count), 32'(model_count));
        end
    endtask

    // One request/grant/release transaction. Called at a negedge with the
    // arbiter idle. Returns the DUT-observed winner, latency from the select
    // edge, and spacing from the previous observed ack (-1 when there is no ack).
    task automatic run_txn(input logic [NUM_REQ-1:0] s, input int hold,
                           output int w_obs, output int lat, output int gap);
        int w, sel_edge, earliest, drop_edge, hold_left, c, obs_edge;
        bit granted, dropped, done;
        logic [31:0] exp_ack;
        req       = s;
        w         = rr_model(s, model_last);
        sel_edge  = edge_no + 1;
        earliest  = (sel_edge + 1 > last_grant_edge + DECIM + 1) ? sel_edge + 1 : last_grant_edge + DECIM + 1;
        granted   = 1'b0;
        dropped   = 1'b0;
        done      = 1'b0;
        drop_edge = 0;
        hold_left = hold;
        c         = 0;
        obs_edge  = -1;
        w_obs     = -1;
        while (!done && c < 80) begin
            drive_data(c);
            c++;
            tick();
            exp_ack = 32'd0;
            if (!granted && edge_no >= earliest && rand_num != 16'h0000) begin
                granted         = 1'b1;
                exp_ack         = 32'd1 << w;
                last_grant_edge = edge_no;
                model_last      = w;
                model_count     = model_count + 16'd1;
                model_byte      = fold(rand_num) & mask[w*8 +: 8];
            end
            if (ack != '0 && obs_edge < 0) begin
                obs_edge = edge_no;
                for (int i = 0; i < NUM_REQ; i++) if (ack[i]) w_obs = i;
            end
            chk_eq("ack", 32'(ack), exp_ack);
            chk_eq("rand_byte", 32'(rand_byte), 32'(model_byte));
            chk_eq("draw_count", 32'(draw_count), 32'(model_count));
            chk_eq("busy", 32'(busy), (dropped && edge_no >= drop_edge) ? 32'd0 : 32'd1);
            if (dropped && edge_no >= drop_edge) begin
                done = 1'b1;
            end else if (granted && !dropped) begin
                if (hold_left == 0) begin
                    req[w]    = 1'b0;
                    dropped   = 1'b1;
                    drop_edge = edge_no + 1;
                end else begin
                    hold_left--;
                end
            end
        end
        chk_eq("txn_done", 32'(done), 32'd1);
        if (obs_edge >= 0) begin
            lat          = obs_edge - sel_edge;
            gap          = obs_edge - last_ack_obs;
            last_ack_obs = obs_edge;
        end else begin
            lat = -1;
            gap = -1;
        end
    endtask

    initial begin
        int w, lat, gap, prev_w;
        logic [15:0] saved;
        logic [NUM_REQ-1:0] rem;
        logic [NUM_REQ-1:0] s;

        reset       = 1'b1;
        req         = '0;
        rand_num    = 16'h1234;
        mask        = '0;
        fix_en      = 1'b0;
        fix_rn      = 16'h0000;
        fix_mask    = '0;
        zero_cycles = 0;
        zero_pct    = 0;
        model_reset();

        // Reset values
        tick();
        tick();
        chk_eq("rst_ack", 32'(ack), 32'd0);
        chk_eq("rst_byte", 32'(rand_byte), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_count", 32'(draw_count), 32'd0);
        reset = 1'b0;
        idle_ticks(2);

        // Single request out of reset: F5^D2 = 0x27
        fix_en         = 1'b1;
        fix_rn         = 16'hF5D2;
        fix_mask       = '0;
        fix_mask[7:0]  = 8'hFF;
        run_txn(NUM_REQ'(1), 0, w, lat, gap);
        chk_eq("tp1_winner", 32'(w), 32'd0);
        chk_eq("tp1_latency", 32'(lat), 32'd1);
        chk_eq("tp1_byte", 32'(rand_byte), 32'h27);
        chk_eq("tp1_count", 32'(draw_count), 32'd1);

        // Mask applied at the grant edge
        fix_mask[7:0] = 8'h0F;
        run_txn(NUM_REQ'(1), 1, w, lat, gap);
        chk_eq("mask_byte", 32'(rand_byte), 32'h07);

        // Zero stall: three reseed cycles, then F5D2
        fix_mask[7:0] = 8'hFF;
        zero_cycles   = 3;
        run_txn(NUM_REQ'(1), 0, w, lat, gap);
        chk_eq("zero_latency", 32'(lat), 32'd3);
        chk_eq("zero_byte", 32'(rand_byte), 32'h27);
        zero_cycles   = 0;

        // Round robin with both requests held, each dropping one cycle after ack
        fix_mask = '1;
        prev_w   = -1;
        for (int i = 0; i < 4; i++) begin
            run_txn('1, 0, w, lat, gap);
            if (i > 0) chk_eq("rr_alternate", 32'(w), 32'((prev_w + 1) % NUM_REQ));
            chk_eq("rr_gap", 32'(gap >= DECIM + 1), 32'd1);
            prev_w = w;
        end

        // Withdrawal in DRAW while the decimation counter is still running
        saved = model_count;
        req   = '0;
        req[1] = 1'b1;
        drive_data(1000);
        tick();
        chk_eq("wd_busy_draw", 32'(busy), 32'd1);
        chk_eq("wd_ack_sel", 32'(ack), 32'd0);
        req = '0;
        drive_data(1000);
        tick();
        chk_eq("wd_ack", 32'(ack), 32'd0);
        chk_eq("wd_busy_idle", 32'(busy), 32'd0);
        chk_eq("wd_count", 32'(draw_count), 32'(saved));
        chk_eq("wd_byte", 32'(rand_byte), 32'(model_byte));
        idle_ticks(DECIM + 1);

        // Reset pulsed in HOLD
        req    = '0;
        req[0] = 1'b1;
        drive_data(1000);
        tick();
        chk_eq("hr_busy", 32'(busy), 32'd1);
        drive_data(1000);
        tick();
        chk_eq("hr_ack", 32'(ack), 32'd1);
        chk_eq("hr_byte", 32'(rand_byte), 32'h27);
        chk_eq("hr_count", 32'(draw_count), 32'(model_count + 16'd1));
        reset = 1'b1;
        #1;
        chk_eq("hr_rst_ack", 32'(ack), 32'd0);
        chk_eq("hr_rst_byte", 32'(rand_byte), 32'd0);
        chk_eq("hr_rst_busy", 32'(busy), 32'd0);
        chk_eq("hr_rst_count", 32'(draw_count), 32'd0);
        req = '0;
        tick();
        reset = 1'b0;
        model_reset();
        idle_ticks(1);
        run_txn('1, 0, w, lat, gap);
        chk_eq("tie_after_reset", 32'(w), 32'd0);
        chk_eq("tie_latency", 32'(lat), 32'd1);

        // Counter wrap from a preloaded 0xFFFF
        idle_ticks(DECIM + 1);
        force dut.draw_count = 16'hFFFF;
        #1;
        release dut.draw_count;
        model_count = 16'hFFFF;
        run_txn(NUM_REQ'(2), 0, w, lat, gap);
        chk_eq("wrap_count", 32'(draw_count), 32'd0);

        // Randomized transactions: random request sets, masks, hold times, reseeds
        fix_en   = 1'b0;
        zero_pct = 25;
        rem      = '0;
        for (int t = 0; t < 200; t++) begin
            s = rem | NUM_REQ'($urandom);
            if (s == '0) s[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
            run_txn(s, int'($urandom_range(0, 2)), w, lat, gap);
            chk_eq("rnd_gap", 32'(gap >= MIN_GAP), 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                idle_ticks(int'($urandom_range(1, 5)));
                rem = '0;
            end else begin
                rem = req;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
